// File: rtl/scale_pair_queue.sv
// scale_pair_queue: pairs one A scale vector with N B scale vectors and buffers the raw pairs in a show-ahead FIFO
module scale_pair_queue #(
    parameter int MAT_SIZE  = 16,
    parameter int FP_MANT_W = 23,
    parameter int FP_EXP_W  = 8,
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 4,
    parameter int REUSE_W   = 4,
    parameter int AF_LEVEL  = DEPTH - 1
) (
    input  logic                          clk,
    input  logic                          rstnn,
    input  logic                          start_i,
    input  logic                          flush_i,
    input  logic [REUSE_W-1:0]            cfg_reuse_i,
    input  logic                          a_valid_i,
    output logic                          a_ready_o,
    input  logic [FP_MANT_W*MAT_SIZE-1:0] a_mant_i,
    input  logic [FP_EXP_W*MAT_SIZE-1:0]  a_exp_i,
    input  logic                          b_valid_i,
    output logic                          b_ready_o,
    input  logic [FP_MANT_W*MAT_SIZE-1:0] b_mant_i,
    input  logic [FP_EXP_W*MAT_SIZE-1:0]  b_exp_i,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [FP_MANT_W*MAT_SIZE-1:0] m_a_mant_o,
    output logic [FP_EXP_W*MAT_SIZE-1:0]  m_a_exp_o,
    output logic [FP_MANT_W*MAT_SIZE-1:0] m_b_mant_o,
    output logic [FP_EXP_W*MAT_SIZE-1:0]  m_b_exp_o,
    output logic [TAG_W-1:0]              m_tag_o,
    output logic                          m_last_o,
    output logic [$clog2(DEPTH):0]        level_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic                          almost_full_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;
    localparam int VW    = (FP_MANT_W + FP_EXP_W) * MAT_SIZE;
    localparam int ENT_W = 2 * VW + TAG_W + 1;
    localparam logic [PW-1:0] AF = PW'(AF_LEVEL);

    logic               a_v_q, a_v_d, b_v_q, b_v_d;
    logic [VW-1:0]      a_q, a_d, b_q, b_d;
    logic [REUSE_W-1:0] reuse_q, reuse_d, cnt_q, cnt_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
    logic [ENT_W-1:0]   mem [DEPTH];

    logic [REUSE_W-1:0] cfg_eff, reuse_eff, cnt_eff;
    logic [TAG_W-1:0]   tag_eff;
    logic               empty, full, last, push, pop, a_cap, b_cap;

    // A start pulse in the same cycle as a push makes that push use the fresh counters
    always_comb begin
        empty     = wr_q == rd_q;
        full      = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);
        cfg_eff   = (cfg_reuse_i == '0) ? REUSE_W'(1) : cfg_reuse_i;
        reuse_eff = start_i ? cfg_eff : reuse_q;
        cnt_eff   = start_i ? '0 : cnt_q;
        tag_eff   = start_i ? '0 : tag_q;
        last      = cnt_eff == reuse_eff - REUSE_W'(1);
        push      = a_v_q & b_v_q & ~full;
        pop       = ~empty & m_ready_i;
        a_ready_o = ~a_v_q | (push & last);
        b_ready_o = ~b_v_q | push;
        a_cap     = a_valid_i & a_ready_o & ~flush_i;
        b_cap     = b_valid_i & b_ready_o & ~flush_i;
    end

    // Next state: flush wins over start, start over normal pairing
    always_comb begin
        a_v_d   = flush_i ? 1'b0 : a_cap ? 1'b1 : (push & last) ? 1'b0 : a_v_q;
        b_v_d   = flush_i ? 1'b0 : b_cap ? 1'b1 : push ? 1'b0 : b_v_q;
        a_d     = a_cap ? {a_mant_i, a_exp_i} : a_q;
        b_d     = b_cap ? {b_mant_i, b_exp_i} : b_q;
        reuse_d = (start_i & ~flush_i) ? cfg_eff : reuse_q;
        cnt_d   = flush_i ? '0 : push ? (last ? '0 : cnt_eff + REUSE_W'(1)) : cnt_eff;
        tag_d   = flush_i ? '0 : push ? tag_eff + TAG_W'(1) : tag_eff;
        wr_d    = flush_i ? '0 : wr_q + PW'(push);
        rd_d    = flush_i ? '0 : rd_q + PW'(pop);
    end

    // Control and hold registers
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            a_v_q   <= 1'b0;
            b_v_q   <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            reuse_q <= REUSE_W'(1);
            cnt_q   <= '0;
            tag_q   <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            a_v_q   <= a_v_d;
            b_v_q   <= b_v_d;
            a_q     <= a_d;
            b_q     <= b_d;
            reuse_q <= reuse_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // FIFO storage needs no reset: the head is masked whenever the queue is empty
    always_ff @(posedge clk) begin
        if (push && !flush_i) mem[wr_q[AW-1:0]] <= {a_q, b_q, tag_eff, last};
    end

    assign {m_a_mant_o, m_a_exp_o, m_b_mant_o, m_b_exp_o, m_tag_o, m_last_o} = empty ? '0 : mem[rd_q[AW-1:0]];
    assign m_valid_o     = ~empty;
    assign empty_o       = empty;
    assign full_o        = full;
    assign level_o       = wr_q - rd_q;
    assign almost_full_o = level_o >= AF;
endmodule

// File: tb/tb_scale_pair_queue.sv
// tb_scale_pair_queue: scoreboard bench for scale_pair_queue
module tb_scale_pair_queue;
    localparam int MS = 2;
    localparam int MW = 23 * MS;
    localparam int EW = 8 * MS;
    localparam int VW = MW + EW;

    typedef struct packed {
        logic [VW-1:0] a;
        logic [VW-1:0] b;
        logic [3:0]    tag;
        logic          last;
    } ent_t;

    logic          clk, rstnn, start_i, flush_i, a_valid_i, a_ready_o, b_valid_i, b_ready_o;
    logic [3:0]    cfg_reuse_i, m_tag_o;
    logic [MW-1:0] a_mant_i, b_mant_i, m_a_mant_o, m_b_mant_o;
    logic [EW-1:0] a_exp_i, b_exp_i, m_a_exp_o, m_b_exp_o;
    logic          m_valid_o, m_ready_i, m_last_o, empty_o, full_o, almost_full_o;
    logic [2:0]    level_o;

    logic [VW-1:0] a_stim[$], b_stim[$];
    ent_t          exp_q[$];
    int            checks = 0, fails = 0, pops = 0, cyc = 0;
    logic [3:0]    tag_m = '0;

    scale_pair_queue #(.MAT_SIZE(MS)) dut (
        .clk(clk), .rstnn(rstnn), .start_i(start_i), .flush_i(flush_i), .cfg_reuse_i(cfg_reuse_i),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_mant_i(a_mant_i), .a_exp_i(a_exp_i),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_mant_i(b_mant_i), .b_exp_i(b_exp_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_a_mant_o(m_a_mant_o), .m_a_exp_o(m_a_exp_o),
        .m_b_mant_o(m_b_mant_o), .m_b_exp_o(m_b_exp_o), .m_tag_o(m_tag_o), .m_last_o(m_last_o),
        .level_o(level_o), .empty_o(empty_o), .full_o(full_o), .almost_full_o(almost_full_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_group(input int nsend, input int reuse, input bit keep);
        logic [VW-1:0] a, b;
        a = VW'({$urandom(), $urandom()});
        a_stim.push_back(a);
        for (int i = 0; i < nsend; i++) begin
            b = VW'({$urandom(), $urandom()});
            b_stim.push_back(b);
            if (keep) exp_q.push_back('{a: a, b: b, tag: tag_m, last: (i == reuse - 1)});
            tag_m++;
        end
    endtask

    task automatic do_start(input logic [3:0] cfg);
        tick();
        cfg_reuse_i = cfg;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tag_m = '0;
    endtask

    task automatic chk_idle(input string p);
        chk({p, "_a_ready"}, a_ready_o, 1);
        chk({p, "_b_ready"}, b_ready_o, 1);
        chk({p, "_m_valid"}, m_valid_o, 0);
        chk({p, "_empty"}, empty_o, 1);
        chk({p, "_full"}, full_o, 0);
        chk({p, "_afull"}, almost_full_o, 0);
        chk({p, "_level"}, level_o, 0);
        chk({p, "_data"}, {m_a_mant_o, m_a_exp_o, m_b_mant_o, m_b_exp_o, m_tag_o, m_last_o}, 0);
    endtask

    task automatic wait_level(input logic [2:0] target, input string n);
        @(negedge clk);
        for (int k = 0; k < 40 && level_o !== target; k++) @(negedge clk);
        chk(n, level_o, target);
    endtask

    task automatic wait_fire(input string n);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (a_valid_i && a_ready_o) break;
        end
        chk(n, a_valid_i && a_ready_o, 1);
    endtask

    task automatic wait_drain(input string n, input bit rnd);
        for (int k = 0; k < 400 && exp_q.size() > 0; k++) begin
            tick();
            if (rnd) m_ready_i = 1'($urandom_range(0, 1));
        end
        m_ready_i = 1'b1;
        chk(n, exp_q.size(), 0);
    endtask

    task automatic wait_pops(input int target, output int at);
        for (int k = 0; k < 100 && pops < target; k++) begin
            @(posedge clk);
            #2;
        end
        at = cyc;
    endtask

    // A-side driver: presents the queue head, retires it after a handshake
    initial begin
        bit f;
        a_valid_i = 1'b0; a_mant_i = '0; a_exp_i = '0;
        forever begin
            @(negedge clk);
            f = a_valid_i && a_ready_o && rstnn && !flush_i;
            @(posedge clk);
            #1;
            if (f && a_stim.size() > 0) void'(a_stim.pop_front());
            a_valid_i = a_stim.size() > 0;
            {a_mant_i, a_exp_i} = (a_stim.size() > 0) ? a_stim[0] : '0;
        end
    end

    // B-side driver
    initial begin
        bit f;
        b_valid_i = 1'b0; b_mant_i = '0; b_exp_i = '0;
        forever begin
            @(negedge clk);
            f = b_valid_i && b_ready_o && rstnn && !flush_i;
            @(posedge clk);
            #1;
            if (f && b_stim.size() > 0) void'(b_stim.pop_front());
            b_valid_i = b_stim.size() > 0;
            {b_mant_i, b_exp_i} = (b_stim.size() > 0) ? b_stim[0] : '0;
        end
    end

    // Monitor: every pop is compared against the oldest expected pair
    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (rstnn && m_valid_o && m_ready_i) begin
                pops++;
                if (exp_q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_pop: got tag %0d with no expected entry", m_tag_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_entry", {m_a_mant_o, m_a_exp_o, m_b_mant_o, m_b_exp_o, m_tag_o, m_last_o}, e);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0, c1, c2;
        rstnn = 1'b0; start_i = 1'b0; flush_i = 1'b0; cfg_reuse_i = '0; m_ready_i = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk_idle("reset");
        tick();
        rstnn = 1'b1;

        do_start(4'd1);
        add_group(1, 1, 1);
        wait_fire("t1_fire");
        @(negedge clk);
        chk("t1_lat_c1", m_valid_o, 0);
        @(negedge clk);
        chk("t1_lat_c2", m_valid_o, 1);
        chk("t1_tag_last", {m_tag_o, m_last_o}, 5'b0000_1);
        tick();
        m_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t1_empty", empty_o, 1);
        chk("t1_zero", {m_a_mant_o, m_a_exp_o, m_b_mant_o, m_b_exp_o}, 0);

        do_start(4'd3);
        add_group(3, 3, 1);
        wait_fire("t2_fire");
        @(negedge clk);
        chk("t2_a_ready_p1", a_ready_o, 0);
        @(negedge clk);
        chk("t2_a_ready_p2", a_ready_o, 0);
        @(negedge clk);
        chk("t2_a_ready_last", a_ready_o, 1);
        wait_drain("t2_drain", 0);

        m_ready_i = 1'b0;
        do_start(4'd1);
        p0 = pops;
        repeat (6) add_group(1, 1, 1);
        wait_level(3'd3, "t3_level3");
        chk("t3_afull3", almost_full_o, 1);
        chk("t3_notfull3", full_o, 0);
        wait_level(3'd4, "t3_level4");
        chk("t3_full4", full_o, 1);
        chk("t3_afull4", almost_full_o, 1);
        repeat (3) @(negedge clk);
        chk("t3_stall_level", level_o, 4);
        chk("t3_stall_a_ready", a_ready_o, 0);
        chk("t3_stall_b_ready", b_ready_o, 0);
        tick();
        m_ready_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t3_pop_level", level_o, 3);
        @(negedge clk);
        chk("t3_pushpop_level", level_o, 3);
        wait_drain("t3_drain", 0);
        chk("t3_pop_count", pops - p0, 6);

        do_start(4'd1);
        repeat (20) add_group(1, 1, 1);
        wait_drain("t4_drain", 1);

        p0 = pops;
        repeat (8) add_group(1, 1, 1);
        wait_pops(p0 + 1, c1);
        wait_pops(p0 + 8, c2);
        chk("t4_throughput", c2 - c1, 7);
        wait_drain("t4b_drain", 0);

        do_start(4'd0);
        repeat (3) add_group(1, 1, 1);
        wait_drain("t5_drain", 0);

        m_ready_i = 1'b0;
        do_start(4'd2);
        add_group(2, 2, 0);
        add_group(1, 2, 0);
        wait_level(3'd3, "t6_level3");
        chk("t6_a_held", a_ready_o, 0);
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        tag_m = '0;
        @(negedge clk);
        chk_idle("flush");
        add_group(2, 2, 1);
        m_ready_i = 1'b1;
        wait_drain("t6_drain", 0);

        m_ready_i = 1'b0;
        do_start(4'd1);
        repeat (3) add_group(1, 1, 0);
        wait_level(3'd2, "t7_level2");
        @(posedge clk);
        #3;
        rstnn = 1'b0;
        #1;
        chk_idle("arst");
        a_stim.delete();
        b_stim.delete();
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        tag_m = '0;
        tick();
        tick();
        rstnn = 1'b1;
        add_group(1, 1, 1);
        m_ready_i = 1'b1;
        wait_drain("t7_drain", 0);

        repeat (3) tick();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
